ro_odometer_scan: RTL and testbench



---
 rtl/ro_odometer_scan.sv | 197 +++++++++++++++++++
 tb/tb_ro_odometer_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_odometer_scan.sv
// ro_odometer_scan: RO odometer controller for the CDIR sensor array.
// It stresses all stressed ROs and then counts edges of one reference/stressed
// pair, or of every pair in turn, over a TIMER-cycle window. It reports both
// counts, their difference floored at zero, and the stressed channel.
// Optional feature: define RO_ODO_THRESH_EN to compile in the aging comparator
// (aged_flag = delta > THRESH). Without it, aged_flag stays 0.
module ro_odometer_scan #(
  parameter int unsigned NO_CDIR      = 8,
  parameter int unsigned TIMER        = 100,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned THRESH       = 4,
  parameter int unsigned MUX_SEL_SIZE = $clog2(NO_CDIR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic                    en_out,
  input  logic                    scan,
  input  logic [MUX_SEL_SIZE-1:0] r_mux_sel,
  input  logic [MUX_SEL_SIZE-1:0] s_mux_sel,
  input  logic [NO_CDIR-1:0]      ro_ref_in,
  input  logic [NO_CDIR-1:0]      ro_str_in,
  output logic [NO_CDIR-1:0]      ro_ref_en,
  output logic [NO_CDIR-1:0]      ro_str_en,
  output logic [CNT_W-1:0]        r_freq,
  output logic [CNT_W-1:0]        s_freq,
  output logic [CNT_W-1:0]        delta,
  output logic [MUX_SEL_SIZE-1:0] chan_out,
  output logic                    aged_flag,
  output logic                    valid_out,
  output logic                    busy
);

  localparam int unsigned             TimerW    = $clog2(TIMER);
  localparam logic [TimerW-1:0]       TimerLast = TimerW'(TIMER - 1);
  localparam logic [MUX_SEL_SIZE-1:0] ChanLast  = MUX_SEL_SIZE'(NO_CDIR - 1);
  localparam logic [NO_CDIR-1:0]      OneHot0   = NO_CDIR'(1);

  // Reject parameter sets the datapath cannot represent.
  if (NO_CDIR < 2 || TIMER < 4 || (CNT_W < 32 && (THRESH >> CNT_W) != 0)) begin : g_param_check
    $error("ro_odometer_scan: illegal parameter set");
  end

  typedef enum logic [1:0] {StIdle, StStress, StMeasure, StDone} state_e;

  state_e                  state_q;
  logic                    scan_q;
  logic [MUX_SEL_SIZE-1:0] ref_ch_q;
  logic [MUX_SEL_SIZE-1:0] str_ch_q;
  logic [TimerW-1:0]       timer_q;
  logic [CNT_W-1:0]        r_cnt_q;
  logic [CNT_W-1:0]        s_cnt_q;

  // Two-flop synchronizers plus a history flop for edge detection, one per RO.
  logic [NO_CDIR-1:0] ref_sync1, ref_sync2, ref_prev;
  logic [NO_CDIR-1:0] str_sync1, str_sync2, str_prev;

  logic                    ref_edge;
  logic                    str_edge;
  logic [MUX_SEL_SIZE-1:0] r_sel_safe;
  logic [MUX_SEL_SIZE-1:0] s_sel_safe;
  logic [MUX_SEL_SIZE-1:0] next_ref_ch;
  logic [MUX_SEL_SIZE-1:0] next_str_ch;
  logic [CNT_W-1:0]        r_cnt_inc;
  logic [CNT_W-1:0]        s_cnt_inc;
  logic [CNT_W-1:0]        delta_c;
  logic                    aged_c;

  // Synchronize every RO output. This state is not cleared between windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync1 <= '0;
      ref_sync2 <= '0;
      ref_prev  <= '0;
      str_sync1 <= '0;
      str_sync2 <= '0;
      str_prev  <= '0;
    end else begin
      ref_sync1 <= ro_ref_in;
      ref_sync2 <= ref_sync1;
      ref_prev  <= ref_sync2;
      str_sync1 <= ro_str_in;
      str_sync2 <= str_sync1;
      str_prev  <= str_sync2;
    end
  end

  assign ref_edge = ref_sync2[ref_ch_q] & ~ref_prev[ref_ch_q];
  assign str_edge = str_sync2[str_ch_q] & ~str_prev[str_ch_q];

  // Channel choice for the next window, counter increments and the result difference.
  always_comb begin
    r_sel_safe = (32'(r_mux_sel) < NO_CDIR) ? r_mux_sel : '0;
    s_sel_safe = (32'(s_mux_sel) < NO_CDIR) ? s_mux_sel : '0;
    if (state_q == StDone) begin
      // Only reached when scanning; both selects follow the channel counter.
      next_ref_ch = str_ch_q + MUX_SEL_SIZE'(1);
      next_str_ch = str_ch_q + MUX_SEL_SIZE'(1);
    end else if (scan) begin
      next_ref_ch = '0;
      next_str_ch = '0;
    end else begin
      next_ref_ch = r_sel_safe;
      next_str_ch = s_sel_safe;
    end
    r_cnt_inc = (r_cnt_q != '1) ? r_cnt_q + CNT_W'(1) : r_cnt_q;
    s_cnt_inc = (s_cnt_q != '1) ? s_cnt_q + CNT_W'(1) : s_cnt_q;
    delta_c   = (s_cnt_q >= r_cnt_q) ? '0 : r_cnt_q - s_cnt_q;
  end

`ifdef RO_ODO_THRESH_EN
  assign aged_c = (delta_c > CNT_W'(THRESH));
`else
  assign aged_c = 1'b0;
`endif

  // Controller FSM with registered enables, counters and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      scan_q    <= 1'b0;
      ref_ch_q  <= '0;
      str_ch_q  <= '0;
      timer_q   <= '0;
      r_cnt_q   <= '0;
      s_cnt_q   <= '0;
      ro_ref_en <= '0;
      ro_str_en <= '0;
      r_freq    <= '0;
      s_freq    <= '0;
      delta     <= '0;
      chan_out  <= '0;
      aged_flag <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q   <= StStress;
            ro_str_en <= '1;
            ro_ref_en <= '0;
          end
        end
        StStress: begin
          if (en_out) begin
            state_q   <= StMeasure;
            scan_q    <= scan;
            ref_ch_q  <= next_ref_ch;
            str_ch_q  <= next_str_ch;
            ro_ref_en <= OneHot0 << next_ref_ch;
            ro_str_en <= OneHot0 << next_str_ch;
            timer_q   <= '0;
            r_cnt_q   <= '0;
            s_cnt_q   <= '0;
            busy      <= 1'b1;
          end
        end
        StMeasure: begin
          if (ref_edge) r_cnt_q <= r_cnt_inc;
          if (str_edge) s_cnt_q <= s_cnt_inc;
          if (timer_q == TimerLast) begin
            state_q <= StDone;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StDone: begin
          r_freq    <= r_cnt_q;
          s_freq    <= s_cnt_q;
          delta     <= delta_c;
          chan_out  <= str_ch_q;
          aged_flag <= aged_c;
          valid_out <= 1'b1;
          if (scan_q && (str_ch_q != ChanLast)) begin
            state_q   <= StMeasure;
            ref_ch_q  <= next_ref_ch;
            str_ch_q  <= next_str_ch;
            ro_ref_en <= OneHot0 << next_ref_ch;
            ro_str_en <= OneHot0 << next_str_ch;
            timer_q   <= '0;
            r_cnt_q   <= '0;
            s_cnt_q   <= '0;
          end else begin
            state_q   <= StStress;
            ro_str_en <= '1;
            ro_ref_en <= '0;
            busy      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_odometer_scan.sv
// Directed bench for ro_odometer_scan: reset, single, scan, fast-stressed,
// mid-measurement reset and ignored-control cases with hand-computed results.
`timescale 1ns / 1ps
module tb_ro_odometer_scan;

  localparam int unsigned NO_CDIR = 8;
  localparam int unsigned TIMER   = 100;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned THRESH  = 4;
  localparam int unsigned SW      = $clog2(NO_CDIR);

  logic               clk = 1'b0;
  logic               rst, go, en_out, scan;
  logic [SW-1:0]      r_mux_sel, s_mux_sel;
  logic [NO_CDIR-1:0] ro_ref_in = '0;
  logic [NO_CDIR-1:0] ro_str_in = '0;
  logic [NO_CDIR-1:0] ro_ref_en, ro_str_en;
  logic [CNT_W-1:0]   r_freq, s_freq, delta;
  logic [SW-1:0]      chan_out;
  logic               aged_flag, valid_out, busy;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  // RO half periods in 5 ns ticks; ticks are offset from clock edges.
  int ref_half [NO_CDIR];
  int str_half [NO_CDIR];
  int ref_tk   [NO_CDIR];
  int str_tk   [NO_CDIR];

  ro_odometer_scan #(
    .NO_CDIR(NO_CDIR), .TIMER(TIMER), .CNT_W(CNT_W), .THRESH(THRESH), .MUX_SEL_SIZE(SW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .en_out(en_out), .scan(scan),
    .r_mux_sel(r_mux_sel), .s_mux_sel(s_mux_sel),
    .ro_ref_in(ro_ref_in), .ro_str_in(ro_str_in),
    .ro_ref_en(ro_ref_en), .ro_str_en(ro_str_en),
    .r_freq(r_freq), .s_freq(s_freq), .delta(delta), .chan_out(chan_out),
    .aged_flag(aged_flag), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    for (int i = 0; i < NO_CDIR; i++) begin
      ref_tk[i] = 0;
      str_tk[i] = 0;
    end
    #2;
    forever begin
      for (int i = 0; i < NO_CDIR; i++) begin
        ref_tk[i]++;
        str_tk[i]++;
        if (ref_tk[i] >= ref_half[i]) begin
          ref_tk[i] = 0;
          ro_ref_in[i] = ~ro_ref_in[i];
        end
        if (str_tk[i] >= str_half[i]) begin
          str_tk[i] = 0;
          ro_str_in[i] = ~ro_str_in[i];
        end
      end
      #5;
    end
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_chk++;
    if (got < exp - tol || got > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic wait_valid(input int bound);
    int w;
    w = 0;
    while (!valid_out && w < bound) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Returns the cycle stamp of the first negedge after the MEASURE entry edge.
  task automatic start_meas(input bit sc, input int r, input int s, output int t0);
    @(negedge clk);
    scan = sc;
    r_mux_sel = SW'(r);
    s_mux_sel = SW'(s);
    en_out = 1'b1;
    @(negedge clk);
    en_out = 1'b0;
    t0 = cyc;
  endtask

  task automatic count_strobes(input int n, output int k);
    k = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid_out) k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tp, k, exp_s, exp_d, d0, d7, exp_aged;
    rst = 1'b1; go = 1'b0; en_out = 1'b0; scan = 1'b0;
    r_mux_sel = '0; s_mux_sel = '0;
    for (int i = 0; i < NO_CDIR; i++) begin
      ref_half[i] = 4;
      str_half[i] = 5;
    end

    // Reset state
    repeat (5) @(negedge clk);
    check("rst r_freq", int'(r_freq), 0, 0);
    check("rst s_freq", int'(s_freq), 0, 0);
    check("rst delta", int'(delta), 0, 0);
    check("rst chan", int'(chan_out), 0, 0);
    check("rst aged", int'(aged_flag), 0, 0);
    check("rst valid", int'(valid_out), 0, 0);
    check("rst busy", int'(busy), 0, 0);
    check("rst ref_en", int'(ro_ref_en), 0, 0);
    check("rst str_en", int'(ro_str_en), 0, 0);
    rst = 1'b0;

    // go -> STRESS
    pulse_go();
    check("stress str_en", int'(ro_str_en), 255, 0);
    check("stress ref_en", int'(ro_ref_en), 0, 0);

    // Single mode: ref 40 ns, stressed 50 ns
    start_meas(1'b0, 2, 6, t0);
    check("single ref_en", int'(ro_ref_en), 4, 0);
    check("single str_en", int'(ro_str_en), 64, 0);
    check("single busy", int'(busy), 1, 0);
    wait_valid(300);
    check("single latency", cyc - t0, TIMER + 1, 0);
    check("single r_freq", int'(r_freq), 25, 1);
    check("single s_freq", int'(s_freq), 20, 1);
    check("single delta", int'(delta), 5, 2);
    check("single chan", int'(chan_out), 6, 0);
`ifdef RO_ODO_THRESH_EN
    exp_aged = (int'(r_freq) - int'(s_freq) > int'(THRESH)) ? 1 : 0;
`else
    exp_aged = 0;
`endif
    check("single aged", int'(aged_flag), exp_aged, 0);
    check("single back str_en", int'(ro_str_en), 255, 0);
    check("single back busy", int'(busy), 0, 0);
    @(negedge clk);
    check("single strobe width", int'(valid_out), 0, 0);

    // Stressed faster than reference: 30 ns vs 40 ns
    for (int i = 0; i < NO_CDIR; i++) str_half[i] = 3;
    start_meas(1'b0, 1, 3, t0);
    wait_valid(300);
    check("fast latency", cyc - t0, TIMER + 1, 0);
    check("fast r_freq", int'(r_freq), 25, 1);
    check("fast s_freq", int'(s_freq), 33, 1);
    check("fast delta", int'(delta), 0, 0);
    check("fast aged", int'(aged_flag), 0, 0);
    check("fast chan", int'(chan_out), 3, 0);

    // Scan: stressed channel i period 40+10*i ns, refs 40 ns
    for (int i = 0; i < NO_CDIR; i++) str_half[i] = 4 + i;
    start_meas(1'b1, 0, 0, t0);
    tp = t0;
    d0 = 0;
    d7 = 0;
    for (int i = 0; i < NO_CDIR; i++) begin
      wait_valid(300);
      exp_s = 1000 / (40 + 10 * i);
      exp_d = 25 - exp_s;
      check("scan spacing", cyc - tp, TIMER + 1, 0);
      check("scan chan", int'(chan_out), i, 0);
      check("scan r_freq", int'(r_freq), 25, 1);
      check("scan s_freq", int'(s_freq), exp_s, 1);
      check("scan delta", int'(delta), exp_d, 2);
      if (i == 0) d0 = int'(delta);
      if (i == NO_CDIR - 1) d7 = int'(delta);
      tp = cyc;
      @(negedge clk);
    end
    check("scan delta trend", (d7 > d0) ? 1 : 0, 1, 0);
    check("scan end str_en", int'(ro_str_en), 255, 0);
    check("scan end busy", int'(busy), 0, 0);

    // Reset 50 cycles into a measurement
    for (int i = 0; i < NO_CDIR; i++) str_half[i] = 5;
    start_meas(1'b0, 2, 6, t0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst valid", int'(valid_out), 0, 0);
    check("mid rst r_freq", int'(r_freq), 0, 0);
    check("mid rst s_freq", int'(s_freq), 0, 0);
    check("mid rst delta", int'(delta), 0, 0);
    check("mid rst chan", int'(chan_out), 0, 0);
    check("mid rst busy", int'(busy), 0, 0);
    check("mid rst ref_en", int'(ro_ref_en), 0, 0);
    check("mid rst str_en", int'(ro_str_en), 0, 0);
    count_strobes(150, k);
    check("mid rst no strobe", k, 0, 0);

    // en_out in IDLE is ignored
    @(negedge clk);
    en_out = 1'b1;
    @(negedge clk);
    en_out = 1'b0;
    @(negedge clk);
    check("idle en_out str_en", int'(ro_str_en), 0, 0);
    check("idle en_out busy", int'(busy), 0, 0);

    // Fresh sequence; go and en_out pulsed mid-measurement are ignored
    pulse_go();
    start_meas(1'b0, 2, 6, t0);
    repeat (30) @(negedge clk);
    go = 1'b1;
    en_out = 1'b1;
    @(negedge clk);
    go = 1'b0;
    en_out = 1'b0;
    wait_valid(300);
    check("restart latency", cyc - t0, TIMER + 1, 0);
    check("restart r_freq", int'(r_freq), 25, 1);
    check("restart s_freq", int'(s_freq), 20, 1);
    check("restart chan", int'(chan_out), 6, 0);
    count_strobes(250, k);
    check("restart single strobe", k, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
